decrypted_msg_checker: RTL and testbench

Reader and key-search controller at the far end of the decrypted-message RAM. After the RC4 decryptor signals that a message is written, this block reads all MSG_LEN bytes back and checks that each is a lowercase ASCII letter or a space. On a pass it freezes the key and lights the success LED. On a failure it increments `secret_key` and pulses `restart` so the decryptor runs again, until the key space is exhausted.

---
 rtl/decrypted_msg_checker.sv | 111 +++++++++++
 tb/tb_decrypted_msg_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypted_msg_checker.sv
// Reads back the decrypted message RAM, checks every byte is a lowercase letter or space,
// and steps the RC4 key (with a decryptor restart) until a message passes or keys run out.
module decrypted_msg_checker #(
  parameter int          MSG_LEN   = 32,
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  q_d,
  output logic [7:0]  address_d,
  output logic [23:0] secret_key,
  output logic        restart,
  output logic        busy,
  output logic        found,
  output logic        exhausted,
  output logic [1:0]  LED
);

  localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    WAIT_RD,
    CHECK,
    FAIL_INC,
    RESTART,
    FOUND,
    EXHAUSTED
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [7:0]  addr_nxt;
  logic [23:0] key_nxt;

  function automatic logic byte_ok(input logic [7:0] b);
    return (b == 8'd32) || ((b >= 8'd97) && (b <= 8'd122));
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    addr_nxt  = address_d;
    key_nxt   = secret_key;
    case (state)
      IDLE: begin
        if (start) begin
          idx_nxt   = 8'd0;
          state_nxt = SET_ADDR;
        end
      end
      SET_ADDR: begin
        addr_nxt  = idx;
        state_nxt = WAIT_RD;
      end
      WAIT_RD: state_nxt = CHECK;
      CHECK: begin
        // First bad byte aborts the pass; the rest of the message is never read.
        if (!byte_ok(q_d)) begin
          state_nxt = FAIL_INC;
        end else if (idx == LAST_IDX) begin
          state_nxt = FOUND;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = SET_ADDR;
        end
      end
      FAIL_INC: begin
        if (secret_key == KEY_MAX) begin
          state_nxt = EXHAUSTED;
        end else begin
          key_nxt   = secret_key + 24'd1;
          state_nxt = RESTART;
        end
      end
      RESTART:   state_nxt = IDLE;
      FOUND:     state_nxt = FOUND;
      EXHAUSTED: state_nxt = EXHAUSTED;
      default:   state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 8'd0;
      address_d  <= 8'd0;
      secret_key <= KEY_START;
      restart    <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      LED        <= 2'b00;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      address_d  <= addr_nxt;
      secret_key <= key_nxt;
      restart    <= (state_nxt == RESTART);
      busy       <= !((state_nxt == IDLE) || (state_nxt == FOUND) || (state_nxt == EXHAUSTED));
      found      <= (state_nxt == FOUND);
      exhausted  <= (state_nxt == EXHAUSTED);
      LED        <= {(state_nxt == FOUND), (state_nxt == EXHAUSTED)};
    end
  end

endmodule

// File: tb/tb_decrypted_msg_checker.sv
// Bench for decrypted_msg_checker: RAM model plus a message-level reference that predicts
// the first failing byte, pulse timing and key progression.
module tb_decrypted_msg_checker;

  localparam int          MSG_LEN = 32;
  localparam logic [23:0] KS      = 24'h000000;
  localparam logic [23:0] KM      = 24'h3FFFFF;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  q_d, address_d;
  logic [23:0] secret_key;
  logic        restart, busy, found, exhausted;
  logic [1:0]  LED;

  logic        start_x;
  logic [7:0]  q_x, address_x;
  logic [23:0] key_x;
  logic        restart_x, busy_x, found_x, exhausted_x;
  logic [1:0]  led_x;

  logic [7:0]  mem   [256];
  logic [7:0]  mem_x [256];
  logic [7:0]  max_addr;
  logic        clr_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decrypted_msg_checker #(.MSG_LEN(MSG_LEN), .KEY_START(KS), .KEY_MAX(KM)) dut (
    .clk(clk), .reset(reset), .start(start), .q_d(q_d), .address_d(address_d),
    .secret_key(secret_key), .restart(restart), .busy(busy), .found(found),
    .exhausted(exhausted), .LED(LED));

  decrypted_msg_checker #(.MSG_LEN(MSG_LEN), .KEY_START(KM), .KEY_MAX(KM)) dut_x (
    .clk(clk), .reset(reset), .start(start_x), .q_d(q_x), .address_d(address_x),
    .secret_key(key_x), .restart(restart_x), .busy(busy_x), .found(found_x),
    .exhausted(exhausted_x), .LED(led_x));

  always @(posedge clk) q_d <= mem[address_d];
  always @(posedge clk) q_x <= mem_x[address_x];

  always @(posedge clk) begin
    if (clr_addr) max_addr <= 8'd0;
    else if (address_d > max_addr) max_addr <= address_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_valid(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  // Reference: index of the first rejected byte, or MSG_LEN if the message passes.
  function automatic int first_bad();
    for (int i = 0; i < MSG_LEN; i++)
      if (!is_valid(mem[i])) return i;
    return MSG_LEN;
  endfunction

  function automatic logic [7:0] rand_valid();
    int r;
    r = $urandom_range(0, 27);
    if (r == 26) return 8'h20;
    if (r == 27) return 8'h7A;
    return 8'h61 + 8'(r);
  endfunction

  function automatic logic [7:0] rand_invalid();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    while (is_valid(v)) v = 8'($urandom_range(0, 255));
    return v;
  endfunction

  task automatic fill_valid();
    for (int i = 0; i < 256; i++) mem[i] = rand_valid();
    mem[0] = 8'h20;
    mem[1] = 8'h7A;
    mem[MSG_LEN-1] = 8'h61;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    start_x = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".addr"}, address_d, 8'd0);
    chk({tag, ".key"}, secret_key, KS);
    chk({tag, ".restart"}, restart, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".found"}, found, 1'b0);
    chk({tag, ".exhausted"}, exhausted, 1'b0);
    chk({tag, ".led"}, LED, 2'b00);
  endtask

  // Pulses start and follows the check; kind: 0 restart, 1 found, 2 exhausted, 3 timeout.
  // With noise set, extra start pulses are injected while the check is running.
  task automatic run_check(input bit noise, output int cyc, output int kind);
    kind = 3;
    cyc = 0;
    start = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      step();
      start = (noise && (n % 7 == 3)) ? 1'b1 : 1'b0;
      if (n == 1) chk("busy_after_start", busy, 1'b1);
      if (restart || found || exhausted) begin
        cyc = n;
        kind = restart ? 0 : (found ? 1 : 2);
        break;
      end
    end
    start = 1'b0;
    chk("bounded_wait", (kind == 3) ? 1 : 0, 0);
  endtask

  task automatic expect_fail(input string tag, input bit noise, inout logic [23:0] exp_key);
    int cyc, kind, fb;
    fb = first_bad();
    run_check(noise, cyc, kind);
    exp_key = exp_key + 24'd1;
    chk({tag, ".kind"}, kind, 0);
    chk({tag, ".cycle"}, cyc, 3 * fb + 5);
    chk({tag, ".key"}, secret_key, exp_key);
    chk({tag, ".busy_in_restart"}, busy, 1'b1);
    step();
    chk({tag, ".restart_one_cycle"}, restart, 1'b0);
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".key_stable"}, secret_key, exp_key);
  endtask

  task automatic expect_pass(input string tag, input logic [23:0] exp_key);
    int cyc, kind;
    run_check(1'b0, cyc, kind);
    chk({tag, ".kind"}, kind, 1);
    chk({tag, ".cycle"}, cyc, 3 * MSG_LEN + 1);
    chk({tag, ".key"}, secret_key, exp_key);
    chk({tag, ".led"}, LED, 2'b10);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".exhausted"}, exhausted, 1'b0);
  endtask

  initial begin
    logic [23:0] exp_key;
    int cyc, kind;
    reset = 1'b0;
    start = 1'b0;
    start_x = 1'b0;
    clr_addr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h61;
      mem_x[i] = 8'h61;
    end
    mem_x[0] = 8'h00;
    step();
    do_reset();
    chk_reset_outputs("reset");
    chk("reset_x.key", key_x, KM);

    // Exhaustion on the single-key instance.
    kind = 3;
    start_x = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      start_x = 1'b0;
      if (restart_x) begin kind = 0; break; end
      if (exhausted_x) begin kind = 2; cyc = n; break; end
    end
    chk("exh.kind", kind, 2);
    chk("exh.cycle", cyc, 5);
    chk("exh.led", led_x, 2'b01);
    chk("exh.key", key_x, KM);
    chk("exh.found", found_x, 1'b0);
    start_x = 1'b1;
    step();
    start_x = 1'b0;
    step();
    chk("exh.sticky", {exhausted_x, busy_x, restart_x}, 3'b100);

    // All-'a' message passes on the first key.
    for (int i = 0; i < 256; i++) mem[i] = 8'h61;
    expect_pass("all_a", KS);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("found_sticky", {found, busy, LED}, 4'b1010);

    // Random failing messages; the first one is 'A' at byte 5.
    do_reset();
    exp_key = KS;
    for (int t = 0; t < 6; t++) begin
      fill_valid();
      case (t)
        0: mem[5] = 8'h41;
        1: mem[$urandom_range(0, MSG_LEN-1)] = 8'h7B;
        2: mem[$urandom_range(0, MSG_LEN-1)] = 8'h60;
        default: begin
          mem[$urandom_range(0, MSG_LEN-1)] = rand_invalid();
          mem[$urandom_range(0, MSG_LEN-1)] = rand_invalid();
        end
      endcase
      clr_addr = 1'b1;
      step();
      clr_addr = 1'b0;
      expect_fail("fail", t[0], exp_key);
      if (t == 0) chk("byte5.max_addr", max_addr, 8'd5);
    end

    // Key search: keys 0..2 fail, then the reloaded RAM passes at key 3.
    do_reset();
    exp_key = KS;
    for (int k = 0; k < 3; k++) begin
      fill_valid();
      mem[$urandom_range(0, MSG_LEN-1)] = rand_invalid();
      expect_fail("search", 1'b0, exp_key);
    end
    fill_valid();
    expect_pass("search_pass", 24'h000003);

    // Reset in the middle of byte 10, with start asserted in the same cycle.
    do_reset();
    fill_valid();
    start = 1'b1;
    for (int n = 1; n <= 31; n++) begin
      step();
      start = 1'b0;
    end
    chk("mid.busy", busy, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk_reset_outputs("mid_reset");
    step();
    chk("mid.start_lost", busy, 1'b0);

    // Fresh start after reset must read from address 0.
    fill_valid();
    mem[0] = 8'h30;
    clr_addr = 1'b1;
    step();
    clr_addr = 1'b0;
    exp_key = KS;
    expect_fail("fresh", 1'b1, exp_key);
    chk("fresh.max_addr", max_addr, 8'd0);

    // Noisy start pulses during a full passing check change nothing.
    do_reset();
    fill_valid();
    run_check(1'b1, cyc, kind);
    chk("noise.kind", kind, 1);
    chk("noise.cycle", cyc, 3 * MSG_LEN + 1);
    chk("noise.key", secret_key, KS);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
